// File: rtl/lane_sweep_scheduler_pkg.sv
// Shared types for the lane sweep scheduler: FSM states, owner encoding and
// the default latch-bank width.
package lane_sweep_scheduler_pkg;

    localparam int LANES_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/lane_sweep_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant (bit 0 = A, bit 1 = B), the
// priority pointer only moves when the caller strobes update on a real grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_b;

    // On a tie, whoever was not served last wins; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (req_a && req_b) begin
            grant = prio_b ? 2'b10 : 2'b01;
        end else if (req_a) begin
            grant = 2'b01;
        end else if (req_b) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            prio_b <= grant[0];
        end
    end

endmodule

// File: rtl/lane_sweep_scheduler.sv
// Shares one external latch bank between two requesters: open the bank for a
// cycle with the granted payload, then read it back one lane per cycle.
module lane_sweep_scheduler
    import lane_sweep_scheduler_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a_req,
    input  logic [LANES-1:0] i_a_data,
    output logic             o_a_ack,
    input  logic             i_b_req,
    input  logic [LANES-1:0] i_b_data,
    output logic             o_b_ack,
    output logic             o_lat_en,
    output logic [LANES-1:0] o_lat_d,
    input  logic [LANES-1:0] i_lat_q,
    output logic [LANES-1:0] o_a,
    output logic [LANES-1:0] o_b,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    state_t           state;
    owner_t           owner;
    logic [IDX_W-1:0] idx;
    logic [LANES-1:0] d_reg;
    logic [1:0]       grant;
    logic             arb_update;

    // The pointer only advances when a grant is actually taken in IDLE.
    assign arb_update = (state == ST_IDLE);

    rr_arb2 u_arb (
        .clk    (i_clk),
        .rst    (i_rst),
        .req_a  (i_a_req),
        .req_b  (i_b_req),
        .update (arb_update),
        .grant  (grant)
    );

    assign o_lat_d = d_reg;
    assign o_idx   = idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_A;
            idx      <= '0;
            d_reg    <= '0;
            o_a      <= '0;
            o_b      <= '0;
            o_lat_en <= 1'b0;
            o_a_ack  <= 1'b0;
            o_b_ack  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_lat_en <= 1'b0;
            o_a_ack  <= 1'b0;
            o_b_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        d_reg    <= grant[1] ? i_b_data : i_a_data;
                        owner    <= grant[1] ? OWN_B : OWN_A;
                        o_lat_en <= 1'b1;
                        o_busy   <= 1'b1;
                        state    <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    idx   <= '0;
                    state <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (owner == OWN_A) begin
                        o_a[idx] <= i_lat_q[idx];
                    end else begin
                        o_b[idx] <= i_lat_q[idx];
                    end
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        o_a_ack <= (owner == OWN_A);
                        o_b_ack <= (owner == OWN_B);
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_sweep_scheduler.sv
// Bench for lane_sweep_scheduler: directed scenarios plus random traffic,
// compared every cycle against a time-since-grant transaction model.
module tb_lane_sweep_scheduler;

    localparam int LANES = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             i_rst;
    logic             i_a_req;
    logic [LANES-1:0] i_a_data;
    logic             o_a_ack;
    logic             i_b_req;
    logic [LANES-1:0] i_b_data;
    logic             o_b_ack;
    logic             o_lat_en;
    logic [LANES-1:0] o_lat_d;
    logic [LANES-1:0] lat_q;
    logic [LANES-1:0] o_a;
    logic [LANES-1:0] o_b;
    logic             o_busy;
    logic [IDX_W-1:0] o_idx;

    int check_count = 0;
    int error_count = 0;

    // Model: m_d counts cycles since the grant edge, -1 when idle.
    int               m_d;
    logic             m_owner;
    logic             m_rr_b;
    logic [LANES-1:0] m_lat_d;
    logic [LANES-1:0] m_a;
    logic [LANES-1:0] m_b;

    lane_sweep_scheduler #(.LANES(LANES), .IDX_W(IDX_W)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_a_req  (i_a_req),
        .i_a_data (i_a_data),
        .o_a_ack  (o_a_ack),
        .i_b_req  (i_b_req),
        .i_b_data (i_b_data),
        .o_b_ack  (o_b_ack),
        .o_lat_en (o_lat_en),
        .o_lat_d  (o_lat_d),
        .i_lat_q  (lat_q),
        .o_a      (o_a),
        .o_b      (o_b),
        .o_busy   (o_busy),
        .o_idx    (o_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_latch begin
        if (o_lat_en) lat_q = o_lat_d;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic rst, input logic a_req, input logic [LANES-1:0] a_data,
                             input logic b_req, input logic [LANES-1:0] b_data);
        if (rst) begin
            m_d = -1; m_a = '0; m_b = '0; m_lat_d = '0; m_rr_b = 1'b0; m_owner = 1'b0;
        end else if (m_d < 0) begin
            if (a_req || b_req) begin
                m_owner = (a_req && b_req) ? m_rr_b : b_req;
                m_lat_d = m_owner ? b_data : a_data;
                m_rr_b  = !m_owner;
                m_d     = 0;
            end
        end else begin
            if (m_d >= 1 && m_d <= LANES) begin
                if (m_owner) m_b[m_d-1] = m_lat_d[m_d-1];
                else         m_a[m_d-1] = m_lat_d[m_d-1];
            end
            m_d++;
            if (m_d == LANES + 2) m_d = -1;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic a_req, input logic [LANES-1:0] a_data,
                                 input logic b_req, input logic [LANES-1:0] b_data);
        i_rst = rst; i_a_req = a_req; i_a_data = a_data; i_b_req = b_req; i_b_data = b_data;
        @(posedge clk);
        modelStep(rst, a_req, a_data, b_req, b_data);
        @(negedge clk);
        checkOutput("lat_en", 32'(o_lat_en), 32'(m_d == 0));
        checkOutput("lat_d", 32'(o_lat_d), 32'(m_lat_d));
        checkOutput("busy", 32'(o_busy), 32'(m_d >= 0 && m_d <= LANES + 1));
        checkOutput("a_ack", 32'(o_a_ack), 32'(m_d == LANES + 1 && !m_owner));
        checkOutput("b_ack", 32'(o_b_ack), 32'(m_d == LANES + 1 && m_owner));
        checkOutput("idx", 32'(o_idx), (m_d >= 1 && m_d <= LANES) ? 32'(m_d - 1) : 32'd0);
        checkOutput("o_a", 32'(o_a), 32'(m_a));
        checkOutput("o_b", 32'(o_b), 32'(m_b));
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        int a_ack_step, b_ack_step, ack_total, last_ack;
        logic a_done, b_done;

        m_d = -1; m_a = '0; m_b = '0; m_lat_d = '0; m_rr_b = 1'b0; m_owner = 1'b0;
        i_rst = 1'b1; i_a_req = 1'b0; i_a_data = '0; i_b_req = 1'b0; i_b_data = '0;

        // Single A transfer: bank open only right after grant, ack ten cycles on.
        doReset();
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_o_a", 32'(o_a), 32'd0);
        a_ack_step = -1;
        for (int s = 1; s <= 14; s++) begin
            applyStimulus(1'b0, a_ack_step < 0, 8'hA5, 1'b0, '0);
            if (s == 1) checkOutput("t1_lat_en_open", 32'(o_lat_en), 32'd1);
            if (s == 2) checkOutput("t1_lat_en_closed", 32'(o_lat_en), 32'd0);
            if (o_a_ack && a_ack_step < 0) a_ack_step = s;
        end
        checkOutput("t1_ack_step", 32'(a_ack_step), 32'd10);
        checkOutput("t1_o_a", 32'(o_a), 32'hA5);
        checkOutput("t1_o_b", 32'(o_b), 32'h0);

        // Simultaneous requests: A wins after reset, B follows one slot later.
        doReset();
        a_done = 1'b0; b_done = 1'b0; a_ack_step = -1; b_ack_step = -1;
        for (int s = 1; s <= 26; s++) begin
            applyStimulus(1'b0, !a_done, 8'h3C, !b_done, 8'hC3);
            if (o_a_ack) begin a_done = 1'b1; if (a_ack_step < 0) a_ack_step = s; end
            if (o_b_ack) begin b_done = 1'b1; if (b_ack_step < 0) b_ack_step = s; end
        end
        checkOutput("t2_a_ack_step", 32'(a_ack_step), 32'd10);
        checkOutput("t2_b_ack_step", 32'(b_ack_step), 32'd21);
        checkOutput("t2_o_a", 32'(o_a), 32'h3C);
        checkOutput("t2_o_b", 32'(o_b), 32'hC3);

        // All-ones payload over a cleared result: bits fill LSB first.
        doReset();
        for (int s = 1; s <= 11; s++) begin
            applyStimulus(1'b0, s == 1, 8'hFF, 1'b0, '0);
            if (s >= 2 && s <= 9) checkOutput("t3_idx", 32'(o_idx), 32'(s - 2));
            if (s >= 3 && s <= 10) checkOutput("t3_o_a", 32'(o_a), (32'd1 << (s - 2)) - 32'd1);
        end

        // Reset in the middle of a sweep drops everything with no ack.
        doReset();
        ack_total = 0;
        for (int s = 1; s <= 6; s++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, '0);
        checkOutput("t4_idx_before", 32'(o_idx), 32'd4);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, '0);
        checkOutput("t4_o_a", 32'(o_a), 32'd0);
        checkOutput("t4_busy", 32'(o_busy), 32'd0);
        checkOutput("t4_idx", 32'(o_idx), 32'd0);
        checkOutput("t4_lat_d", 32'(o_lat_d), 32'd0);
        for (int s = 1; s <= 15; s++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
            if (o_a_ack || o_b_ack) ack_total++;
        end
        checkOutput("t4_no_ack", 32'(ack_total), 32'd0);

        // Request dropped and payload changed after grant: original data lands.
        doReset();
        a_ack_step = -1;
        for (int s = 1; s <= 12; s++) begin
            applyStimulus(1'b0, s == 1, (s == 1) ? 8'h5A : 8'($urandom), 1'b0, '0);
            if (o_a_ack && a_ack_step < 0) a_ack_step = s;
        end
        checkOutput("t5_ack_step", 32'(a_ack_step), 32'd10);
        checkOutput("t5_o_a", 32'(o_a), 32'h5A);

        // Both held continuously: grants alternate A,B,A,B with acks 11 apart.
        doReset();
        ack_total = 0; last_ack = -1;
        for (int s = 1; s <= 50; s++) begin
            applyStimulus(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
            if (o_a_ack || o_b_ack) begin
                checkOutput("t6_ack_owner", 32'(o_b_ack), 32'(ack_total % 2));
                if (last_ack >= 0) checkOutput("t6_ack_spacing", 32'(s - last_ack), 32'd11);
                last_ack = s;
                ack_total++;
            end
        end
        checkOutput("t6_ack_count", 32'(ack_total), 32'd4);

        // Random traffic with occasional reset.
        doReset();
        for (int s = 0; s < 500; s++) begin
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                          $urandom_range(0, 2) != 0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, want finish before limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/lane_sweep_scheduler.md
LANE_SWEEP_SCHEDULER -- requirements
Module: lane_sweep_scheduler

Interface
REQ-001 The block SHALL have parameter LANES, default 8, giving the latch-bank width in bit lanes.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(LANES), giving the sweep index width.
REQ-003 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous and active-high.
REQ-005 Port i_a_req  input  1  requester A wants one transfer; held until o_a_ack.
REQ-006 Port i_a_data  input  LANES  requester A payload, sampled at grant.
REQ-007 Port o_a_ack  output  1  one-cycle pulse, A transfer complete.
REQ-008 Port i_b_req  input  1  requester B request; same rules as A.
REQ-009 Port i_b_data  input  LANES  requester B payload.
REQ-010 Port o_b_ack  output  1  one-cycle pulse, B transfer complete.
REQ-011 Port o_lat_en  output  1  gate of the shared latch bank; high means transparent.
REQ-012 Port o_lat_d  output  LANES  data presented to the latch bank.
REQ-013 Port i_lat_q  input  LANES  latch-bank outputs.
REQ-014 Port o_a  output  LANES  result register for A; registered.
REQ-015 Port o_b  output  LANES  result register for B; registered.
REQ-016 Port o_busy  output  1  high in every state except IDLE.
REQ-017 Port o_idx  output  IDX_W  current sweep index.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, OPEN, SWEEP and DONE.
REQ-019 In IDLE with any request high, the block SHALL grant one requester.
- The granted payload SHALL be registered into d_reg.
- The grant owner SHALL be recorded.
- The FSM SHALL go to OPEN.
REQ-020 Arbitration SHALL be two-way round-robin.
- On simultaneous requests, the requester not granted last SHALL win.
- After reset, A SHALL win first.
REQ-021 In OPEN, o_lat_en SHALL be 1 for exactly one cycle, o_lat_d SHALL equal d_reg, and the next state SHALL be SWEEP with idx=0.
REQ-022 Outside OPEN, o_lat_en SHALL be 0, and o_lat_d SHALL hold d_reg.
REQ-023 In SWEEP, each cycle the block SHALL copy i_lat_q[idx] into bit idx of the owner's result register, then increment idx.
- Lanes SHALL be copied LSB first.
- All other bits SHALL hold.
- The non-owner register SHALL be unchanged.
REQ-024 When idx==LANES-1 in SWEEP, the FSM SHALL go to DONE and idx SHALL wrap to 0.
REQ-025 In DONE, the owner's ack SHALL be high for one cycle, and the FSM SHALL then return to IDLE.
REQ-026 Latency SHALL be fixed: request sampled in IDLE at cycle T gives OPEN at T+1, SWEEP at T+2..T+LANES+1 and ack at T+LANES+2 (T+10 for LANES=8).
REQ-027 The minimum spacing between grants SHALL be LANES+3 cycles.
REQ-028 Requests SHALL be ignored outside IDLE.
REQ-029 Deasserting a request after grant SHALL NOT abort the transfer; the ack SHALL still be issued.
REQ-030 Payload changes after the grant cycle SHALL NOT affect the transfer.
REQ-031 A request still high in the IDLE cycle after its own ack SHALL be treated as a new request.
REQ-032 The block SHALL never assert o_a_ack and o_b_ack in the same cycle.

Reset
REQ-033 While i_rst is high at a clock edge, the block SHALL set:
- state to IDLE, idx to 0, d_reg to 0;
- o_a, o_b, o_lat_d to 0;
- o_lat_en, o_a_ack, o_b_ack, o_busy to 0;
- the round-robin pointer to favour A.
REQ-034 Reset in any state SHALL abort the transfer immediately, with no ack issued and no partial result retained.
REQ-035 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-036 A shared package SHALL hold the state enum, the LANES default and the owner encoding (OWN_A, OWN_B).
REQ-037 The round-robin arbiter SHALL be a single sub-module named rr_arb2 (inputs: two requests, update strobe; outputs: one-hot grant).
REQ-038 The latch bank SHALL be external to the block; the block SHALL contain no latches.

Verification (bench latch model: transparent when o_lat_en=1, holds otherwise)
REQ-039 Reset, then A requests with 8'hA5 at T -> o_lat_en=1 only at T+1, o_a=8'hA5 and o_a_ack pulse at T+10, o_b=0.
REQ-040 A=8'h3C and B=8'hC3 request together -> A acked at T+10, B at T+21, final o_a=8'h3C, o_b=8'hC3.
REQ-041 A=8'hFF over o_a=0 -> after sweep step k, o_a equals lower k+1 bits set (8'h01, 8'h03, ... 8'hFF) and o_idx equals k during that step.
REQ-042 Reset asserted at sweep idx 4 -> next cycle all outputs 0, FSM in IDLE, no ack ever issued for that transfer.
REQ-043 A drops its request and changes i_a_data after grant -> ack still at T+10 with the original payload.
REQ-044 A and B both held high continuously -> grants alternate A,B,A,B with acks spaced 11 cycles.
